// File: rtl/tboom_rename_pkg.sv
// tboom_rename_pkg: shared rename-stage tag/pointer types and register-file sizing.
package tboom_rename_pkg;
    localparam int REG_PHYS_ADDR_WIDTH = 6;
    localparam int NUM_PHYS_REGISTERS  = 64;
    localparam int NUM_ARCH_REGISTERS  = 32;
    localparam int FL_IDX_WIDTH        = $clog2(NUM_PHYS_REGISTERS);
    localparam int FL_PTR_WIDTH        = FL_IDX_WIDTH + 1;
    localparam int FL_INIT_FREE        = NUM_PHYS_REGISTERS - NUM_ARCH_REGISTERS;

    typedef logic [REG_PHYS_ADDR_WIDTH-1:0] phys_tag_t;
    typedef logic [FL_PTR_WIDTH-1:0]        fl_ptr_t;
    typedef logic [FL_IDX_WIDTH-1:0]        fl_idx_t;

    function automatic phys_tag_t fl_reset_entry(input int k);
        return (k < FL_INIT_FREE) ? phys_tag_t'(NUM_ARCH_REGISTERS + k) : '0;
    endfunction
endpackage

// File: rtl/tboom_free_list_ram.sv
// tboom_free_list_ram: 2-read/2-write free-list storage, reset to the initially free tags.
module tboom_free_list_ram
    import tboom_rename_pkg::*;
(
    input  logic      clk,
    input  logic      rst_n,
    input  fl_idx_t   raddr0,
    input  fl_idx_t   raddr1,
    output phys_tag_t rdata0,
    output phys_tag_t rdata1,
    input  logic      we0,
    input  fl_idx_t   waddr0,
    input  phys_tag_t wdata0,
    input  logic      we1,
    input  fl_idx_t   waddr1,
    input  phys_tag_t wdata1
);
    phys_tag_t mem [NUM_PHYS_REGISTERS];

    assign rdata0 = mem[raddr0];
    assign rdata1 = mem[raddr1];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_PHYS_REGISTERS; k++) mem[k] <= fl_reset_entry(k);
        end else begin
            if (we0) mem[waddr0] <= wdata0;
            if (we1) mem[waddr1] <= wdata1;
        end
    end
endmodule

// File: rtl/tboom_free_list.sv
// tboom_free_list: dual-alloc/dual-free physical register free list with one head checkpoint; TBOOM_FREELIST_ASSERT_EN adds sim checks.
module tboom_free_list
    import tboom_rename_pkg::*;
(
    input  logic      clk,
    input  logic      rst_n,
    input  logic      checkpoint,
    input  logic      flush,
    input  logic      i0_req_valid,
    input  logic      i1_req_valid,
    input  logic      i0_commit_valid,
    input  phys_tag_t i0_commit_pdst_old,
    input  logic      i1_commit_valid,
    input  phys_tag_t i1_commit_pdst_old,
    output logic      i0_pdst_valid,
    output logic      i1_pdst_valid,
    output phys_tag_t i0_pdst,
    output phys_tag_t i1_pdst,
    output logic      freelist_empty,
    output logic      freelist_one_remaining
);
    fl_ptr_t   head, tail, ckpt_head, head_nxt, tail_nxt, count;
    logic      g0, g1;
    fl_idx_t   raddr1, waddr1;
    phys_tag_t rdata0, rdata1;

    assign count                  = tail - head;
    assign freelist_empty         = count == '0;
    assign freelist_one_remaining = count == fl_ptr_t'(1);

    // A flush drops this cycle's requests; i1 takes the slot after i0 only when i0 is granted.
    assign g0       = i0_req_valid && !flush && count != '0;
    assign g1       = i1_req_valid && !flush && (g0 ? count >= fl_ptr_t'(2) : count != '0);
    assign raddr1   = g0 ? fl_idx_t'(head) + fl_idx_t'(1) : fl_idx_t'(head);
    assign head_nxt = flush ? ckpt_head : head + fl_ptr_t'(g0) + fl_ptr_t'(g1);
    assign waddr1   = fl_idx_t'(tail) + fl_idx_t'(i0_commit_valid);
    assign tail_nxt = tail + fl_ptr_t'(i0_commit_valid) + fl_ptr_t'(i1_commit_valid);

    tboom_free_list_ram u_ram (
        .clk    (clk),
        .rst_n  (rst_n),
        .raddr0 (fl_idx_t'(head)),
        .raddr1 (raddr1),
        .rdata0 (rdata0),
        .rdata1 (rdata1),
        .we0    (i0_commit_valid),
        .waddr0 (fl_idx_t'(tail)),
        .wdata0 (i0_commit_pdst_old),
        .we1    (i1_commit_valid),
        .waddr1 (waddr1),
        .wdata1 (i1_commit_pdst_old)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head          <= '0;
            tail          <= fl_ptr_t'(FL_INIT_FREE);
            ckpt_head     <= '0;
            i0_pdst_valid <= 1'b0;
            i1_pdst_valid <= 1'b0;
            i0_pdst       <= '0;
            i1_pdst       <= '0;
        end else begin
            head          <= head_nxt;
            tail          <= tail_nxt;
            ckpt_head     <= checkpoint ? head_nxt : ckpt_head;
            i0_pdst_valid <= g0;
            i1_pdst_valid <= g1;
            if (g0) i0_pdst <= rdata0;
            if (g1) i1_pdst <= rdata1;
        end
    end

`ifdef TBOOM_FREELIST_ASSERT_EN
    // Shadow copy of storage lets us derive which tag values currently sit between head and tail.
    phys_tag_t                     shadow [NUM_PHYS_REGISTERS];
    logic [NUM_PHYS_REGISTERS-1:0] in_fifo;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_PHYS_REGISTERS; k++) shadow[k] <= fl_reset_entry(k);
        end else begin
            if (i0_commit_valid) shadow[fl_idx_t'(tail)] <= i0_commit_pdst_old;
            if (i1_commit_valid) shadow[waddr1] <= i1_commit_pdst_old;
        end
    end

    always_comb begin
        in_fifo = '0;
        for (int k = 0; k < NUM_PHYS_REGISTERS; k++)
            if (fl_ptr_t'(k) < count) in_fifo[shadow[fl_idx_t'(head) + fl_idx_t'(k)]] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            assert (count <= fl_ptr_t'(NUM_PHYS_REGISTERS)) else $error("free list over-full");
            assert (!(g0 && count == '0)) else $error("i0 granted from empty list");
            assert (!(g1 && count < fl_ptr_t'(g0 ? 2 : 1))) else $error("i1 granted without enough tags");
            assert (!(i0_commit_valid && in_fifo[i0_commit_pdst_old])) else $error("i0 frees a free tag");
            assert (!(i1_commit_valid && (in_fifo[i1_commit_pdst_old] ||
                      (i0_commit_valid && i0_commit_pdst_old == i1_commit_pdst_old))))
                else $error("i1 frees a free tag");
        end
    end
`endif
endmodule

// File: tb/tb_tboom_free_list.sv
// tb_tboom_free_list: directed checks of allocation, free, checkpoint/flush, flags and reset.
module tb_tboom_free_list;
    import tboom_rename_pkg::*;

    logic      clk = 1'b0;
    logic      rst_n;
    logic      checkpoint, flush, i0_req_valid, i1_req_valid;
    logic      i0_commit_valid, i1_commit_valid;
    phys_tag_t i0_commit_pdst_old, i1_commit_pdst_old;
    logic      i0_pdst_valid, i1_pdst_valid, freelist_empty, freelist_one_remaining;
    phys_tag_t i0_pdst, i1_pdst;
    int        n_checks = 0;
    int        n_fail   = 0;

    always #5 clk = ~clk;

    tboom_free_list dut (
        .clk                    (clk),
        .rst_n                  (rst_n),
        .checkpoint             (checkpoint),
        .flush                  (flush),
        .i0_req_valid           (i0_req_valid),
        .i1_req_valid           (i1_req_valid),
        .i0_commit_valid        (i0_commit_valid),
        .i0_commit_pdst_old     (i0_commit_pdst_old),
        .i1_commit_valid        (i1_commit_valid),
        .i1_commit_pdst_old     (i1_commit_pdst_old),
        .i0_pdst_valid          (i0_pdst_valid),
        .i1_pdst_valid          (i1_pdst_valid),
        .i0_pdst                (i0_pdst),
        .i1_pdst                (i1_pdst),
        .freelist_empty         (freelist_empty),
        .freelist_one_remaining (freelist_one_remaining)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Drive one cycle of inputs, then sample 1 time unit after the edge.
    task automatic step(input logic r0, input logic r1, input logic ck, input logic fl,
                        input logic c0v, input int c0t, input logic c1v, input int c1t);
        i0_req_valid       = r0;
        i1_req_valid       = r1;
        checkpoint         = ck;
        flush              = fl;
        i0_commit_valid    = c0v;
        i0_commit_pdst_old = phys_tag_t'(c0t);
        i1_commit_valid    = c1v;
        i1_commit_pdst_old = phys_tag_t'(c1t);
        @(posedge clk);
        #1;
    endtask

    task automatic expect_grant(input string tag, input logic v0, input int t0,
                                input logic v1, input int t1);
        check({tag, ".v0"}, int'(i0_pdst_valid), int'(v0));
        check({tag, ".v1"}, int'(i1_pdst_valid), int'(v1));
        if (v0) check({tag, ".t0"}, int'(i0_pdst), t0);
        if (v1) check({tag, ".t1"}, int'(i1_pdst), t1);
    endtask

    task automatic expect_flags(input string tag, input logic e, input logic one);
        check({tag, ".empty"}, int'(freelist_empty), int'(e));
        check({tag, ".one"}, int'(freelist_one_remaining), int'(one));
    endtask

    initial begin
        rst_n = 1'b0;
        step(0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0, 0, 0);
        expect_grant("reset", 0, 0, 0, 0);
        check("reset.p0", int'(i0_pdst), 0);
        check("reset.p1", int'(i1_pdst), 0);
        expect_flags("reset", 0, 0);
        rst_n = 1'b1;

        step(1, 1, 0, 0, 0, 0, 0, 0);
        expect_grant("first_dual", 1, 32, 1, 33);
        step(0, 0, 1, 0, 0, 0, 0, 0);
        expect_grant("ckpt_idle", 0, 0, 0, 0);
        check("hold.p0", int'(i0_pdst), 32);
        step(1, 1, 0, 0, 0, 0, 0, 0);
        expect_grant("spec_dual", 1, 34, 1, 35);
        step(0, 0, 0, 1, 0, 0, 0, 0);
        expect_grant("flush", 0, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0, 0, 0);
        expect_grant("replay_dual", 1, 34, 1, 35);

        step(0, 0, 0, 0, 1, 5, 1, 6);
        expect_grant("commit56", 0, 0, 0, 0);
        for (int j = 0; j < 14; j++) begin
            step(1, 1, 0, 0, 0, 0, 0, 0);
            expect_grant($sformatf("drain%0d", j), 1, 36 + 2 * j, 1, 37 + 2 * j);
        end
        expect_flags("two_left", 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0);
        expect_grant("single5", 1, 5, 0, 0);
        expect_flags("one_left", 0, 1);
        step(1, 1, 0, 0, 0, 0, 0, 0);
        expect_grant("last6", 1, 6, 0, 0);
        expect_flags("empty", 1, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0);
        expect_grant("req_empty", 0, 0, 0, 0);

        step(0, 0, 0, 0, 0, 0, 1, 40);
        expect_flags("i1_free", 0, 1);
        step(0, 1, 0, 0, 0, 0, 0, 0);
        expect_grant("i1_only", 0, 0, 1, 40);

        // Refill 32 tags across the storage wrap point, then drain them in order.
        for (int j = 0; j < 16; j++) step(0, 0, 0, 0, 1, 10 + 2 * j, 1, 11 + 2 * j);
        expect_flags("refill", 0, 0);
        for (int j = 0; j < 16; j++) begin
            step(1, 1, 0, 0, 0, 0, 0, 0);
            expect_grant($sformatf("wrap%0d", j), 1, 10 + 2 * j, 1, 11 + 2 * j);
        end
        expect_flags("wrap_empty", 1, 0);

        step(0, 0, 0, 0, 1, 7, 0, 0);
        step(0, 0, 1, 0, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0, 0, 0);
        expect_grant("one_dual", 1, 7, 0, 0);
        step(1, 1, 0, 1, 1, 9, 0, 0);
        expect_grant("flush_req", 0, 0, 0, 0);
        expect_flags("flush_req", 0, 0);
        step(1, 1, 0, 0, 0, 0, 0, 0);
        expect_grant("after_flush", 1, 7, 1, 9);
        expect_flags("after_flush", 1, 0);

        step(0, 0, 1, 0, 1, 3, 0, 0);
        rst_n = 1'b0;
        step(1, 1, 0, 0, 1, 4, 0, 0);
        expect_grant("mid_reset", 0, 0, 0, 0);
        check("mid_reset.p0", int'(i0_pdst), 0);
        check("mid_reset.p1", int'(i1_pdst), 0);
        expect_flags("mid_reset", 0, 0);
        rst_n = 1'b1;
        step(1, 1, 0, 0, 0, 0, 0, 0);
        expect_grant("post_reset", 1, 32, 1, 33);
        step(0, 0, 0, 1, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0, 0, 0);
        expect_grant("ckpt_cleared", 1, 32, 1, 33);

        step(0, 0, 0, 0, 0, 0, 0, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
